// File: rtl/puf_soc_pkg.sv
// Shared definitions for the RO PUF evaluation stage: FSM encoding and
// the fixed pipeline depths of the RO front end.
package puf_soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Settling time after start so no stale or metastable edge is counted
    localparam int ARM_CYCLES  = 2;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/puf_soc_ro_eval_if.sv
// Control/result bundle between the PUF sequencer and the RO evaluation stage.
interface puf_soc_ro_eval_if #(
    parameter int CNT_BIT_SIZE = 16,
    parameter int WIN_BIT_SIZE = 16
);
    logic                    start;
    logic [WIN_BIT_SIZE-1:0] win_len;
    logic                    ro_a;
    logic                    ro_b;
    logic                    busy;
    logic                    done;
    logic                    resp;
    logic                    tie;
    logic                    ovf;
    logic [CNT_BIT_SIZE-1:0] cnt_a;
    logic [CNT_BIT_SIZE-1:0] cnt_b;

    modport master (
        output start, win_len, ro_a, ro_b,
        input  busy, done, resp, tie, ovf, cnt_a, cnt_b
    );

    modport slave (
        input  start, win_len, ro_a, ro_b,
        output busy, done, resp, tie, ovf, cnt_a, cnt_b
    );

endinterface

// File: rtl/puf_soc_ro_edge_cnt.sv
// Synchronizes one free-running RO output into clk, detects its rising edges
// and counts them in a saturating counter while enabled.
module puf_soc_ro_edge_cnt
    import puf_soc_pkg::*;
#(
    parameter int CNT_BIT_SIZE = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_ro,
    output logic [CNT_BIT_SIZE-1:0] o_cnt,
    output logic                    o_sat
);

    localparam logic [CNT_BIT_SIZE-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0]  sync_reg;
    logic [SYNC_STAGES-1:0]  sync_next;
    logic                    prev_reg;
    logic [CNT_BIT_SIZE-1:0] cnt_reg;
    logic [CNT_BIT_SIZE-1:0] cnt_next;
    logic                    rise;

    assign sync_next = {sync_reg[SYNC_STAGES-2:0], i_ro};
    assign rise      = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    assign o_sat     = (cnt_reg == CNT_MAX);
    assign o_cnt     = cnt_reg;

    // Counter holds at all-ones so a runaway RO cannot wrap into a small count
    always_comb begin
        cnt_next = cnt_reg;
        if (i_clr) begin
            cnt_next = '0;
        end else if (i_en && rise && !o_sat) begin
            cnt_next = cnt_reg + CNT_BIT_SIZE'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_STAGES-1];
            cnt_reg  <= cnt_next;
        end
    end

endmodule

// File: rtl/puf_soc_ro_eval.sv
// RO PUF evaluation: counts edges of two ROs over an N-cycle window and
// produces the response bit (A faster than B), the tie flag and raw counts.
module puf_soc_ro_eval
    import puf_soc_pkg::*;
#(
    parameter int CNT_BIT_SIZE = 16,
    parameter int WIN_BIT_SIZE = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    puf_soc_ro_eval_if.slave bus
);

    state_t                  state_reg, state_next;
    logic [1:0]              arm_cnt_reg, arm_cnt_next;
    logic [WIN_BIT_SIZE-1:0] win_len_reg, win_len_next;
    logic [WIN_BIT_SIZE-1:0] win_cnt_reg, win_cnt_next;

    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    resp_reg, resp_next;
    logic                    tie_reg, tie_next;
    logic                    ovf_reg, ovf_next;
    logic [CNT_BIT_SIZE-1:0] cnt_a_reg, cnt_a_next;
    logic [CNT_BIT_SIZE-1:0] cnt_b_reg, cnt_b_next;

    logic                    accept;
    logic                    count_en;
    logic [1:0]              ro_vec;
    logic [CNT_BIT_SIZE-1:0] cnt_vec [2];
    logic [1:0]              sat_vec;

    assign accept   = (state_reg == ST_IDLE) && bus.start;
    assign count_en = (state_reg == ST_COUNT);
    assign ro_vec   = {bus.ro_b, bus.ro_a};

    // Index 0 is RO A, index 1 is RO B
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ro
            puf_soc_ro_edge_cnt #(
                .CNT_BIT_SIZE(CNT_BIT_SIZE)
            ) u_edge_cnt (
                .i_clk  (i_clk),
                .i_rst_n(i_rst_n),
                .i_clr  (accept),
                .i_en   (count_en),
                .i_ro   (ro_vec[gi]),
                .o_cnt  (cnt_vec[gi]),
                .o_sat  (sat_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            arm_cnt_reg <= '0;
            win_len_reg <= '0;
            win_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            resp_reg    <= 1'b0;
            tie_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            cnt_a_reg   <= '0;
            cnt_b_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            arm_cnt_reg <= arm_cnt_next;
            win_len_reg <= win_len_next;
            win_cnt_reg <= win_cnt_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            resp_reg    <= resp_next;
            tie_reg     <= tie_next;
            ovf_reg     <= ovf_next;
            cnt_a_reg   <= cnt_a_next;
            cnt_b_reg   <= cnt_b_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        arm_cnt_next = '0;
        win_len_next = win_len_reg;
        win_cnt_next = win_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    win_len_next = bus.win_len;
                    state_next   = ST_ARM;
                end
            end
            ST_ARM: begin
                arm_cnt_next = arm_cnt_reg + 2'd1;
                if (arm_cnt_reg == 2'(ARM_CYCLES - 1)) begin
                    arm_cnt_next = '0;
                    win_cnt_next = win_len_reg;
                    state_next   = (win_len_reg == '0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                win_cnt_next = win_cnt_reg - WIN_BIT_SIZE'(1);
                if (win_cnt_reg == WIN_BIT_SIZE'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Busy spans acceptance through the cycle in which done is visible
    always_comb begin
        busy_next  = accept | (busy_reg & ~done_reg);
        done_next  = (state_reg == ST_DONE);
        resp_next  = resp_reg;
        tie_next   = tie_reg;
        ovf_next   = ovf_reg;
        cnt_a_next = cnt_a_reg;
        cnt_b_next = cnt_b_reg;
        if (accept) begin
            resp_next  = 1'b0;
            tie_next   = 1'b0;
            ovf_next   = 1'b0;
            cnt_a_next = '0;
            cnt_b_next = '0;
        end else if (state_reg == ST_DONE) begin
            resp_next  = (cnt_vec[0] > cnt_vec[1]);
            tie_next   = (cnt_vec[0] == cnt_vec[1]);
            ovf_next   = |sat_vec;
            cnt_a_next = cnt_vec[0];
            cnt_b_next = cnt_vec[1];
        end
    end

    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.resp  = resp_reg;
    assign bus.tie   = tie_reg;
    assign bus.ovf   = ovf_reg;
    assign bus.cnt_a = cnt_a_reg;
    assign bus.cnt_b = cnt_b_reg;

endmodule

// File: tb/tb_puf_soc_ro_eval.sv
// Bench for puf_soc_ro_eval: a 16-bit and a 4-bit counter instance see the same
// RO waveforms; expected counts come from the recorded per-cycle RO samples.
module tb_puf_soc_ro_eval;

    localparam int CW   = 16;
    localparam int CW4  = 4;
    localparam int WW   = 16;
    localparam int HMAX = 8192;

    typedef struct {
        int n;
        int ma;  int pa;  int pha;
        int mb;  int pb;  int phb;
        bit chk;
        int ea;  int eb;
        bit eresp;
        bit etie;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [WW-1:0] win_len;
    logic          ro_a;
    logic          ro_b;

    int cyc = 0;
    bit hist_a [HMAX];
    bit hist_b [HMAX];
    int mode_a, per_a, ph_a, mode_b, per_b, ph_b;
    int errors, checks;

    puf_soc_ro_eval_if #(.CNT_BIT_SIZE(CW),  .WIN_BIT_SIZE(WW)) bus16 ();
    puf_soc_ro_eval_if #(.CNT_BIT_SIZE(CW4), .WIN_BIT_SIZE(WW)) bus4 ();

    assign bus16.start   = start;
    assign bus16.win_len = win_len;
    assign bus16.ro_a    = ro_a;
    assign bus16.ro_b    = ro_b;
    assign bus4.start    = start;
    assign bus4.win_len  = win_len;
    assign bus4.ro_a     = ro_a;
    assign bus4.ro_b     = ro_b;

    puf_soc_ro_eval #(.CNT_BIT_SIZE(CW), .WIN_BIT_SIZE(WW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus16)
    );

    puf_soc_ro_eval #(.CNT_BIT_SIZE(CW4), .WIN_BIT_SIZE(WW)) dut4 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what each rising clock edge samples on the RO pins
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HMAX) begin
            hist_a[cyc] = ro_a;
            hist_b[cyc] = ro_b;
        end
    end

    function automatic logic wave(input int mode, input int per, input int ph, input int c);
        logic v;
        v = 1'b0;
        if (mode == 1) v = (((c + ph) % per) < (per / 2)) ? 1'b1 : 1'b0;
        else if (mode == 2) v = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
        return v;
    endfunction

    always @(negedge clk) begin
        ro_a = wave(mode_a, per_a, ph_a, cyc + 1);
        ro_b = wave(mode_b, per_b, ph_b, cyc + 1);
    end

    // An RO rise sampled at edge j reaches the counter two edges later, so a window
    // accepted at E0 covers the sampled 0->1 transitions at edges E0+1 .. E0+N.
    function automatic int rises(input bit which, input int lo, input int hi);
        int r;
        r = 0;
        for (int j = lo; j <= hi; j++) begin
            if (which == 1'b0) begin
                if (hist_a[j] && !hist_a[j-1]) r++;
            end else begin
                if (hist_b[j] && !hist_b[j-1]) r++;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint exp);
        checks++;
        if (act < exp - 1 || act > exp + 1) begin
            errors++;
            $display("FAIL %s: got %0d required %0d +/- 1", name, act, exp);
        end
    endtask

    task automatic set_waves(input int ma, input int pa, input int pha,
                             input int mb, input int pb, input int phb);
        @(negedge clk);
        mode_a = ma; per_a = pa; ph_a = pha;
        mode_b = mb; per_b = pb; ph_b = phb;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_run(input string tag, input int n, input bit disturb);
        int e0, dcyc, ra, rb;
        longint m16, m4, a16, b16, a4, b4;
        @(negedge clk);
        win_len = WW'(n);
        start   = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        check({tag, ".busy_rise"}, longint'(bus16.busy), 1);
        check({tag, ".clear"}, longint'({bus16.resp, bus16.tie, bus16.ovf,
                                         bus4.resp, bus4.tie, bus4.ovf}), 0);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            repeat (3) @(negedge clk);
            start   = 1'b1;
            win_len = WW'($urandom_range(1, 400));
            @(negedge clk);
            start   = 1'b0;
            win_len = WW'($urandom_range(0, 400));
        end
        dcyc = -1;
        while (dcyc < 0 && cyc < e0 + n + 20) begin
            @(posedge clk);
            #1;
            if (bus16.done === 1'b1) dcyc = cyc;
        end
        check({tag, ".done_latency"}, longint'(dcyc - e0), longint'(n + 3));
        check({tag, ".busy_with_done"}, longint'({bus16.busy, bus4.done, bus4.busy}), 7);

        ra  = rises(1'b0, e0 + 1, e0 + n);
        rb  = rises(1'b1, e0 + 1, e0 + n);
        m16 = (64'd1 << CW) - 1;
        m4  = (64'd1 << CW4) - 1;
        a16 = (ra > m16) ? m16 : ra;
        b16 = (rb > m16) ? m16 : rb;
        a4  = (ra > m4) ? m4 : ra;
        b4  = (rb > m4) ? m4 : rb;

        check({tag, ".cnt_a"}, longint'(bus16.cnt_a), a16);
        check({tag, ".cnt_b"}, longint'(bus16.cnt_b), b16);
        check({tag, ".resp"},  longint'(bus16.resp), (a16 > b16) ? 1 : 0);
        check({tag, ".tie"},   longint'(bus16.tie),  (a16 == b16) ? 1 : 0);
        check({tag, ".ovf"},   longint'(bus16.ovf),  (a16 == m16 || b16 == m16) ? 1 : 0);
        check({tag, ".cnt4_a"}, longint'(bus4.cnt_a), a4);
        check({tag, ".cnt4_b"}, longint'(bus4.cnt_b), b4);
        check({tag, ".resp4"},  longint'(bus4.resp), (a4 > b4) ? 1 : 0);
        check({tag, ".tie4"},   longint'(bus4.tie),  (a4 == b4) ? 1 : 0);
        check({tag, ".ovf4"},   longint'(bus4.ovf),  (a4 == m4 || b4 == m4) ? 1 : 0);

        $display("run %s N=%0d E0=%0d done@+%0d cnt_a=%0d cnt_b=%0d resp=%0b tie=%0b ovf=%0b | w4 cnt_a=%0d cnt_b=%0d resp=%0b ovf=%0b",
                 tag, n, e0, dcyc - e0, bus16.cnt_a, bus16.cnt_b, bus16.resp, bus16.tie,
                 bus16.ovf, bus4.cnt_a, bus4.cnt_b, bus4.resp, bus4.ovf);

        @(posedge clk);
        #1;
        check({tag, ".done_fall"}, longint'({bus16.done, bus16.busy, bus4.done, bus4.busy}), 0);
    endtask

    vec_t tbl [8];

    initial begin
        bit seen;
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        win_len = '0;
        ro_a    = 1'b0;
        ro_b    = 1'b0;
        mode_a = 1; per_a = 3; ph_a = 0;
        mode_b = 2; per_b = 2; ph_b = 0;

        tbl[0] = '{100, 1, 4, 0,  1, 6, 1,  1, 25, 17, 1'b1, 1'b0};
        tbl[1] = '{60,  1, 6, 2,  1, 6, 2,  1, 10, 10, 1'b0, 1'b1};
        tbl[2] = '{60,  1, 12, 0, 1, 6, 0,  1, 5,  10, 1'b0, 1'b0};
        tbl[3] = '{100, 1, 4, 1,  0, 2, 0,  1, 25, 0,  1'b1, 1'b0};
        tbl[4] = '{0,   1, 4, 0,  1, 6, 0,  1, 0,  0,  1'b0, 1'b1};
        tbl[5] = '{1,   1, 2, 0,  1, 3, 0,  0, 0,  0,  1'b0, 1'b0};
        tbl[6] = '{37,  2, 2, 0,  2, 2, 0,  0, 0,  0,  1'b0, 1'b0};
        tbl[7] = '{200, 2, 2, 0,  1, 2, 1,  0, 0,  0,  1'b0, 1'b0};

        // Reset held with ROs toggling
        repeat (6) @(posedge clk);
        #1;
        check("reset_outputs", longint'({bus16.busy, bus16.done, bus16.resp, bus16.tie,
                                         bus16.ovf, bus16.cnt_a, bus16.cnt_b}), 0);
        check("reset_outputs4", longint'({bus4.busy, bus4.done, bus4.resp, bus4.tie,
                                          bus4.ovf, bus4.cnt_a, bus4.cnt_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_reset", longint'({bus16.busy, bus16.done, bus4.busy, bus4.done}), 0);

        for (int i = 0; i < 8; i++) begin
            set_waves(tbl[i].ma, tbl[i].pa, tbl[i].pha, tbl[i].mb, tbl[i].pb, tbl[i].phb);
            do_run($sformatf("tbl%0d", i), tbl[i].n, 1'b0);
            if (tbl[i].chk) begin
                check_near($sformatf("tbl%0d.exp_cnt_a", i), longint'(bus16.cnt_a), tbl[i].ea);
                check_near($sformatf("tbl%0d.exp_cnt_b", i), longint'(bus16.cnt_b), tbl[i].eb);
                check($sformatf("tbl%0d.exp_resp", i), longint'(bus16.resp), longint'(tbl[i].eresp));
                check($sformatf("tbl%0d.exp_tie", i),  longint'(bus16.tie),  longint'(tbl[i].etie));
            end
        end

        for (int i = 0; i < 8; i++) begin
            set_waves($urandom_range(0, 2), $urandom_range(2, 9), $urandom_range(0, 8),
                      $urandom_range(0, 2), $urandom_range(2, 9), $urandom_range(0, 8));
            do_run($sformatf("rnd%0d", i), $urandom_range(0, 150), 1'b0);
        end

        // Start pulse and window change during COUNT must not disturb the run
        set_waves(1, 4, 0, 1, 6, 0);
        do_run("ignore_start", 50, 1'b1);

        // Asynchronous reset in the middle of a window
        set_waves(1, 4, 0, 1, 6, 0);
        @(negedge clk);
        win_len = WW'(80);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", longint'({bus16.busy, bus16.done, bus16.resp, bus16.tie,
                                       bus16.ovf, bus16.cnt_a, bus16.cnt_b}), 0);
        check("async_reset4", longint'({bus4.busy, bus4.done, bus4.cnt_a, bus4.cnt_b}), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus16.done || bus16.busy || bus4.done || bus4.busy) seen = 1'b1;
        end
        check("no_activity_after_abort", longint'(seen), 0);
        do_run("post_reset", 40, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
